spi_host_master: RTL
====================

# spi_host_master

Byte/word SPI master for the board's soft control CPU; it drives the same four-wire link that the guest core's SPI slave (SPI_SCK, SPI_DI, SPI_DO, SPI_SS2, SPI_SS3, CONF_DATA0) receives. It serialises CPU-written data in mode 0 and returns the MISO byte in parallel. It also owns the chip-select lines, which can stay asserted across multi-byte commands. A CPU register-file wrapper sits above it; board pins sit below it.

## Interface
- `NUM_CS`, 3, number of chip-select outputs (bit0→CONF_DATA0, bit1→SS2, bit2→SS3).
- `DIV_W`, 8, width of the clock-divisor input.
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `divisor`  in  DIV_W  half-period of spi_sck is H = divisor+1 clk cycles; sampled at accept.
- `cs_mask`  in  NUM_CS  active-high select set for the transfer; sampled at accept.
- `cs_hold`  in  1  1 = keep selects asserted after the transfer; sampled at accept.
- `wide`  in  1  1 = 16-bit transfer (only with SPI_HOST_WIDE_EN).
- `tx_data`  in  16  data to shift, MSB first; bits [15:8] are used only for wide transfers.
- `req`  in  1  start request; accepted when req=1 and busy=0.
- `busy`  out  1  transfer or CS gap in progress.
- `rx_data`  out  16  received data, right-aligned; upper bits are 0 for 8-bit transfers.
- `rx_valid`  out  1  one-cycle pulse when rx_data is updated.
- `spi_sck`  out  1  serial clock, idle low.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in, synchronised by two flops before use.
- `spi_cs_n`  out  NUM_CS  active-low selects.

## Operation
- Reset values: spi_sck=0, spi_mosi=0, spi_cs_n=all 1, busy=0, rx_valid=0, rx_data=0, held-select register cleared, FSM in IDLE.
- FSM states: IDLE → (GAP) → LEAD → HI ⇄ LO → END → (GAP) → IDLE.
- Accept in IDLE: latch divisor, cs_mask, cs_hold, wide, tx_data. Set N = 16 if wide, else N = 8. busy rises the next cycle.
- Select change: if selects are currently held and the latched cs_mask differs from the held mask, go to GAP first. GAP drives all spi_cs_n high for H cycles, then goes to LEAD. Otherwise go directly to LEAD.
- LEAD: drive spi_cs_n = ~cs_mask and spi_mosi = MSB; spi_sck=0 for H cycles.
- LEAD/LO → HI: spi_sck rises and the synchronised MISO bit is shifted into rx_shift.
- HI lasts H cycles, then spi_sck falls.
  - If bits remain: shift tx, present the next MOSI bit, enter LO for H cycles.
  - After bit N: enter END.
- END, one cycle: rx_data ← rx_shift, rx_valid=1.
  - If cs_hold: record the held mask and go to IDLE.
  - Else: release all spi_cs_n and go to GAP for H cycles, then IDLE.
- req while busy is ignored; it is not queued.
- cs_mask=0: transfer still clocks; no select asserts.
- Divisor arithmetic: unsigned, DIV_W bits; counter reloads with divisor and counts down to 0. divisor=all-ones gives H = 2^DIV_W.

## Timing
- 8-bit transfer:
  - busy high for 16H+1 cycles with cs_hold=1, or 17H+1 with cs_hold=0.
  - rx_valid pulses in cycle 16H+1 after the accept edge.
- Wide transfer: replace 16H with 32H.
- When a GAP precedes LEAD, add H cycles.
- MOSI is stable at least H cycles before each rising spi_sck edge.
- MISO sample point is 2 clk after the rising edge (synchroniser latency). This is valid for H ≥ 3. H < 3 is supported only for loopback and same-clock slaves.
- Async reset mid-transfer: all outputs return to their reset values immediately; no rx_valid is issued.

## Configuration
- SPI_HOST_WIDE_EN defined: `wide` is honoured and 16-bit transfers are available.
- SPI_HOST_WIDE_EN undefined: `wide` is ignored and treated as 0; tx_data[15:8] is ignored; rx_data[15:8] is tied to 0.

## Test plan
- divisor=0, cs_mask=3'b001, cs_hold=0, tx 0xA5, MISO looped to MOSI → 8 sck pulses, rx_data=0x00A5, rx_valid at cycle 17, spi_cs_n[0] high for 1 cycle before busy falls.
- divisor=3, tx 0x3C, slave model returns 0xC3 → each sck half-period is 4 clk, rx_data=0x00C3, busy high 65 cycles.
- cs_hold=1, two bytes 0x12 then 0x34 on mask 3'b010 → spi_cs_n[1] stays low across both bytes with no gap; then a req with mask 3'b100 → 1 GAP period with all spi_cs_n high before SS3 asserts.
- With SPI_HOST_WIDE_EN, wide=1, tx 0xBEEF, loopback → 16 sck pulses, rx_data=0xBEEF. Without the macro → 8 pulses, rx_data=0x00EF.
- Pulse reset_n low at cycle 10 of a transfer → spi_cs_n=all 1, spi_sck=0, busy=0, no rx_valid. A new req after release completes normally.
- req held high continuously for 3 transfers → each is accepted only when busy=0, with no overlap and exactly 3 rx_valid pulses.

Source files
------------

// File: rtl/spi_host_master_if.sv
// CPU-side request/response bundle for spi_host_master.
// The register-file wrapper uses the master modport; the SPI engine uses the slave modport.
interface spi_host_master_if #(
  parameter int NUM_CS = 3,
  parameter int DIV_W  = 8
);
  logic [DIV_W-1:0]  divisor;
  logic [NUM_CS-1:0] cs_mask;
  logic              cs_hold;
  logic              wide;
  logic [15:0]       tx_data;
  logic              req;
  logic              busy;
  logic [15:0]       rx_data;
  logic              rx_valid;

  modport master (
    output divisor, cs_mask, cs_hold, wide, tx_data, req,
    input  busy, rx_data, rx_valid
  );

  modport slave (
    input  divisor, cs_mask, cs_hold, wide, tx_data, req,
    output busy, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_host_master.sv
// Mode-0 SPI master with held chip selects.
// The SPI_HOST_WIDE_EN macro enables 16-bit transfers; without it `wide` is ignored.
// The SCK half-period is H = divisor+1 clk cycles. MISO passes through a 2-flop
// synchroniser and is sampled 2 clk after each rising SCK edge.
module spi_host_master #(
  parameter int NUM_CS = 3,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_host_master_if.slave  bus,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_LEAD = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_LO   = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  logic [2:0]        r_state, w_state_nx;
  logic [DIV_W-1:0]  r_div, r_cnt, w_div_eff;
  logic [NUM_CS-1:0] r_mask, r_held_mask, w_mask_eff, r_cs_n;
  logic              r_hold, r_held, r_gap_post;
  logic [4:0]        r_bits;
  logic [15:0]       r_tx, r_rx_shift, r_rx_data, w_tx_load, w_rx_shift_nx;
  logic              r_miso_s1, r_miso_s2, r_p1, r_p2;
  logic              r_sck, r_mosi, r_busy, r_rx_valid;
  logic              w_wide, w_accept, w_gap_needed, w_cnt_zero, w_enter_hi;

`ifdef SPI_HOST_WIDE_EN
  assign w_wide      = bus.wide;
  assign w_tx_load   = w_wide ? bus.tx_data : {bus.tx_data[7:0], 8'h00};
  assign bus.rx_data = r_rx_data;
`else
  assign w_wide      = 1'b0;
  assign w_tx_load   = {bus.tx_data[7:0], 8'h00};
  assign bus.rx_data = {8'h00, r_rx_data[7:0]};
`endif

  assign w_accept     = (r_state == S_IDLE) && bus.req;
  assign w_gap_needed = r_held && (bus.cs_mask != r_held_mask);
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_div_eff    = w_accept ? bus.divisor : r_div;
  assign w_mask_eff   = w_accept ? bus.cs_mask : r_mask;
  assign w_enter_hi   = (w_state_nx == S_HI) && (r_state != S_HI);
  // A sample is due 2 clk after each SCK rise; r_p2 marks that edge.
  assign w_rx_shift_nx = r_p2 ? {r_rx_shift[14:0], r_miso_s2} : r_rx_shift;

  // Next-state logic for the transfer sequencer.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nx and no latch is inferred.
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_accept)   w_state_nx = w_gap_needed ? S_GAP : S_LEAD;
      S_GAP:  if (w_cnt_zero) w_state_nx = r_gap_post ? S_IDLE : S_LEAD;
      S_LEAD: if (w_cnt_zero) w_state_nx = S_HI;
      S_HI:   if (w_cnt_zero) w_state_nx = (r_bits == 5'd1) ? S_END : S_LO;
      S_LO:   if (w_cnt_zero) w_state_nx = S_HI;
      S_END:  w_state_nx = r_hold ? S_IDLE : S_GAP;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Two-flop synchroniser on the asynchronous MISO pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= spi_miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Sequencer state, half-period timer, shift registers and registered pin drivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_held_mask <= '0;
      r_hold      <= 1'b0;
      r_held      <= 1'b0;
      r_gap_post  <= 1'b0;
      r_bits      <= '0;
      r_tx        <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_p1        <= 1'b0;
      r_p2        <= 1'b0;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_busy      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_cs_n      <= '1;
    end else begin
      r_state <= w_state_nx;

      // Every state change enters a state with its own duration, so reload there.
      if (w_state_nx != r_state)  r_cnt <= w_div_eff;
      else if (r_state != S_IDLE) r_cnt <= r_cnt - 1'b1;

      if (w_accept) begin
        r_div      <= bus.divisor;
        r_mask     <= bus.cs_mask;
        r_hold     <= bus.cs_hold;
        r_bits     <= w_wide ? 5'd16 : 5'd8;
        r_tx       <= w_tx_load;
        r_mosi     <= w_tx_load[15];
        r_held     <= 1'b0;
        r_gap_post <= 1'b0;
      end else if (r_state == S_HI && w_cnt_zero) begin
        r_bits <= r_bits - 1'b1;
        r_tx   <= {r_tx[14:0], 1'b0};
        if (r_bits != 5'd1) r_mosi <= r_tx[14];
      end

      if (r_state == S_END) begin
        if (r_hold) begin
          r_held      <= 1'b1;
          r_held_mask <= r_mask;
        end else begin
          r_gap_post  <= 1'b1;
        end
      end

      r_p1       <= w_enter_hi;
      r_p2       <= r_p1;
      r_rx_shift <= w_accept ? '0 : w_rx_shift_nx;

      // For H=1 the last bit is still in the first sync flop when END is entered.
      if (w_state_nx == S_END && r_state != S_END)
        r_rx_data <= r_p1 ? {w_rx_shift_nx[14:0], r_miso_s1} : w_rx_shift_nx;

      r_rx_valid <= (w_state_nx == S_END);
      r_sck      <= (w_state_nx == S_HI);
      r_busy     <= (w_state_nx != S_IDLE);

      // IDLE keeps whatever the selects were: released after a GAP, asserted when held.
      case (w_state_nx)
        S_GAP:                       r_cs_n <= '1;
        S_LEAD, S_HI, S_LO, S_END:   r_cs_n <= ~w_mask_eff;
        default:                     r_cs_n <= r_cs_n;
      endcase
    end
  end

  assign spi_sck      = r_sck;
  assign spi_mosi     = r_mosi;
  assign spi_cs_n     = r_cs_n;
  assign bus.busy     = r_busy;
  assign bus.rx_valid = r_rx_valid;

endmodule
